// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit sampling and a
// first-word-fall-through FIFO holding {parity_err, frame_err, data} per frame.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 57600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          rx_pin,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_frame_err,
  output logic                          rd_parity_err,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun
);

  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int TW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic [1:0]           sync_vld;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [3:0]           sub_cnt;
  logic [3:0]           bit_cnt;
  logic                 samp7, samp8;
  logic                 maj;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_err, parity_err;
  logic                 push;

  assign tick = (state != S_IDLE) && (tick_cnt == TW'(DIV - 1));
  assign maj  = (samp7 & samp8) | (samp7 & sync2) | (samp8 & sync2);

  // Receiver. A start needs a high level seen from the pin itself (armed), so a line
  // held low through reset, or still low after a framing error, cannot begin a frame.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync_vld   <= 2'b00;
      armed      <= 1'b0;
      tick_cnt   <= '0;
      sub_cnt    <= '0;
      bit_cnt    <= '0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      shift      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      push       <= 1'b0;
    end else begin
      sync1    <= rx_pin;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      push     <= 1'b0;
      if (state == S_IDLE) begin
        tick_cnt <= '0;
        sub_cnt  <= '0;
        bit_cnt  <= '0;
        if (sync_vld[1] && sync2)
          armed <= 1'b1;
        if (armed && !sync2) begin
          state      <= S_START;
          armed      <= 1'b0;
          frame_err  <= 1'b0;
          parity_err <= 1'b0;
        end
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          sub_cnt <= sub_cnt + 4'd1;
          if (sub_cnt == 4'd7) samp7 <= sync2;
          if (sub_cnt == 4'd8) samp8 <= sync2;
          case (state)
            S_START: begin
              if (sub_cnt == 4'd9 && maj)
                state <= S_IDLE;
              else if (sub_cnt == 4'd15)
                state <= S_DATA;
            end
            S_DATA: begin
              if (sub_cnt == 4'd9)
                shift <= {maj, shift[DATA_BITS-1:1]};
              if (sub_cnt == 4'd15) begin
                if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
                  state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
            end
            S_PARITY: begin
              // Odd parity errs when the total XOR is 0, even when it is 1.
              if (sub_cnt == 4'd9)
                parity_err <= (PARITY == 1) ? ~(^shift ^ maj) : (^shift ^ maj);
              if (sub_cnt == 4'd15)
                state <= S_STOP;
            end
            S_STOP: begin
              if (sub_cnt == 4'd9) begin
                if (!maj) frame_err <= 1'b1;
                if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  state <= S_IDLE;
                  push  <= 1'b1;
                end
              end else if (sub_cnt == 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          pop, accept;

  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign accept   = push && ((count != CW'(FIFO_DEPTH)) || pop);
  assign head     = mem[rd_ptr];

  assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
  assign rd_frame_err  = rd_valid & head[DATA_BITS];
  assign rd_parity_err = rd_valid & head[DATA_BITS+1];

  always_ff @(posedge CLK) begin
    if (accept)
      mem[wr_ptr] <= {parity_err, frame_err, shift};
  end

  // FIFO bookkeeping; a push into a full FIFO with no pop is dropped and flagged.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 57600, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9, data bits per frame.
REQ-004 Parameter PARITY, default 0, encoding: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two from 2 to 256.
REQ-007 CLK  input  1  single system clock; all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 rx_pin  input  1  asynchronous serial line, idle high.
REQ-010 rd_data  output  DATA_BITS  head-of-FIFO data, LSB = first bit received.
REQ-011 rd_frame_err  output  1  head entry had a bad stop bit.
REQ-012 rd_parity_err  output  1  head entry failed parity; always 0 when PARITY=0.
REQ-013 rd_valid  output  1  FIFO not empty.
REQ-014 rd_ready  input  1  consumer accepts head entry.
REQ-015 count  output  clog2(FIFO_DEPTH)+1  entries held.
REQ-016 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-017 rx_pin SHALL pass through a 2-flop synchroniser before any use; synchroniser flops reset to 1.
REQ-018 Oversample tick SHALL fire once every DIV = (CLK_HZ + 8*BAUD) / (16*BAUD) clocks (integer division); defaults give DIV = 109.
REQ-019 Tick counter SHALL run only outside IDLE and SHALL restart from 0 on leaving IDLE.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE -> START SHALL occur on a synchronised high-to-low transition; a line low since reset SHALL NOT start a frame.
REQ-022 Each bit SHALL span 16 ticks; the bit value SHALL be the majority of the samples at ticks 7, 8 and 9.
REQ-023 START: a majority-high start bit SHALL return the FSM to IDLE (glitch reject) with no push; majority-low SHALL go to DATA.
REQ-024 DATA SHALL shift in DATA_BITS bits LSB-first, then go to PARITY if PARITY!=0, else to STOP.
REQ-025 PARITY: parity_err SHALL be set when the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
REQ-026 STOP SHALL sample STOP_BITS stop bits; frame_err SHALL be set if any stop bit is majority-low.
REQ-027 On the tick-9 sample of the last stop bit, the FSM SHALL return to IDLE and issue a push on the next clock.
REQ-028 A FIFO entry SHALL hold {parity_err, frame_err, data}; errored frames SHALL be pushed, not discarded.
REQ-029 Returning to IDLE with the line low after a frame error SHALL require a high level before a new start is accepted.
REQ-030 FIFO SHALL be first-word-fall-through: rd_valid and rd_* SHALL reflect the head entry; rd_valid SHALL rise the clock after the push into an empty FIFO.
REQ-031 Pop SHALL occur iff rd_valid && rd_ready on a clock edge; rd_ready with rd_valid low SHALL have no effect.
REQ-032 Push SHALL be accepted if count < FIFO_DEPTH, or if count == FIFO_DEPTH and a pop occurs the same cycle.
REQ-033 Simultaneous push and pop SHALL leave count unchanged.
REQ-034 Otherwise a push into a full FIFO SHALL be dropped and overrun SHALL pulse high for exactly one clock; FIFO contents SHALL be unchanged.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-036 reset SHALL immediately force FSM to IDLE, tick and bit counters to 0, pointers and count to 0, rd_valid 0, overrun 0, rd_data/rd_frame_err/rd_parity_err 0.
REQ-037 reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a new high-to-low edge.

Verification
REQ-038 Defaults, 17360 ns bit time, frames 0xF4, 0x7E, 0x03, 0x55, 0x57, 0x41 sent back-to-back, rd_ready=1 -> six pops in order with identical data, all error flags 0, overrun never high.
REQ-039 Defaults, rd_ready=0, 17 frames 0x00..0x10 sent -> count reaches 16, 17th frame gives one overrun pulse; draining yields 0x00..0x0F.
REQ-040 PARITY=2, DATA_BITS=7, frame 0x41 with the wrong parity bit -> rd_data 0x41, rd_parity_err 1; correct parity bit -> rd_parity_err 0.
REQ-041 Defaults, 0x7E sent with the stop bit held low, then line high for 2 bit times -> entry 0x7E with rd_frame_err 1; next frame 0xC0 received clean.
REQ-042 Defaults, 3 us low glitch on an idle line -> no push, FSM back in IDLE; a following frame 0xFF is received correctly.
REQ-043 Defaults, reset pulsed during data bit 4 of frame 0xF0, then frame 0xFC sent -> FIFO holds only 0xFC, count 1.
